// File: rtl/uart_mmio_pkg.sv
// Shared register map, status bit positions and default address region for the UART MMIO block.
// Pure constants and one helper; no storage, no timing, no flow control.
package uart_mmio_pkg;

    localparam logic [2:0] OFF_TX_STATUS = 3'd0;
    localparam logic [2:0] OFF_RX_STATUS = 3'd1;
    localparam logic [2:0] OFF_RX_DATA   = 3'd2;
    localparam logic [2:0] OFF_TX_DATA   = 3'd3;
    localparam logic [2:0] OFF_CYCLE     = 3'd4;
    localparam logic [2:0] OFF_CLEAR     = 3'd5;

    localparam int ST_READY_BIT = 0;
    localparam int ST_OVF_BIT   = 1;

    localparam logic [3:0] REGION_DEFAULT = 4'b1000;

    function automatic logic [31:0] status_word(input logic ready, input logic ovf);
        logic [31:0] w;
        w = '0;
        w[ST_READY_BIT] = ready;
        w[ST_OVF_BIT]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is combinational, push/pop land on the next edge.
// Push when full is accepted only alongside a pop; pop when empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Equal index with differing wrap bit means the writer has lapped the reader.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART front end: register decode, TX/RX FIFOs, sticky overflow flags, cycle counter.
// Reads are zero-latency; TX drains and RX fills by valid/ready, RX ready drops while the RX FIFO is full.
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int         TX_DEPTH  = 8,
    parameter int         RX_DEPTH  = 8,
    parameter logic [3:0] REGION    = REGION_DEFAULT,
    parameter int         CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [7:0]  DataIn,
    output logic        DataInValid,
    input  logic        DataInReady,
    input  logic [7:0]  DataOut,
    input  logic        DataOutValid,
    output logic        DataOutReady
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [2:0]           reg_off;
    logic                 acc, rd_acc, wr_acc;
    logic                 tx_wr, clr_wr, cyc_wr;
    logic                 tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]           tx_head;
    logic                 rx_full, rx_empty, rx_push, rx_pop;
    logic [7:0]           rx_head;
    logic                 tx_ovf_set, rx_ovf_set;
    logic                 tx_ovf_q, tx_ovf_d;
    logic                 rx_ovf_q, rx_ovf_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          rd_mux;
    logic                 unused_bits;

    assign hit     = (addr[31:28] == REGION) && (addr[27:5] == '0);
    assign reg_off = addr[4:2];
    assign acc     = hit && !stall;
    assign rd_acc  = acc && rd_en;
    assign wr_acc  = acc && wr_en;
    assign tx_wr   = wr_acc && (reg_off == OFF_TX_DATA);
    assign clr_wr  = wr_acc && (reg_off == OFF_CLEAR);
    assign cyc_wr  = wr_acc && (reg_off == OFF_CYCLE);

    // A store into a full TX FIFO still lands if the transmitter frees a slot on the same edge.
    assign tx_pop     = !tx_empty && DataInReady;
    assign tx_push    = tx_wr && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_wr && tx_full && !tx_pop;

    assign rx_pop     = rd_acc && (reg_off == OFF_RX_DATA) && !rx_empty;
    assign rx_push    = DataOutValid && !rx_full;
    assign rx_ovf_set = DataOutValid && rx_full;

    assign DataIn       = tx_head;
    assign DataInValid  = !tx_empty;
    assign DataOutReady = !rx_full;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (tx_push),
        .push_dat (wdata[7:0]),
        .pop      (tx_pop),
        .head     (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (rx_push),
        .push_dat (DataOut),
        .pop      (rx_pop),
        .head     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    always_comb begin
        // Set has priority over a same-cycle clear so no overflow event is lost.
        tx_ovf_d = tx_ovf_set || (tx_ovf_q && !(clr_wr && wdata[0]));
        rx_ovf_d = rx_ovf_set || (rx_ovf_q && !(clr_wr && wdata[1]));
        // The write cycle itself counts as 0, so the next cycle already reads 1.
        cnt_d    = cyc_wr ? CNT_ONE : cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_ovf_q <= 1'b0;
            rx_ovf_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            tx_ovf_q <= tx_ovf_d;
            rx_ovf_q <= rx_ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_off)
            OFF_TX_STATUS: rd_mux = status_word(!tx_full, tx_ovf_q);
            OFF_RX_STATUS: rd_mux = status_word(!rx_empty, rx_ovf_q);
            OFF_RX_DATA:   if (!rx_empty) rd_mux = {24'd0, rx_head};
            OFF_CYCLE:     rd_mux = 32'(cnt_q);
            default:       rd_mux = '0;
        endcase
        rdata = hit ? rd_mux : 32'd0;
    end

    assign unused_bits = ^{wdata[31:8], addr[1:0]};

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Scoreboarded bench: directed scenarios then random traffic, checked against a queue-based model.
module tb_uart_mmio_ctrl;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rd_en, wr_en, stall;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, rdata_w;
    logic        hit, hit_w;
    logic [7:0]  DataIn, DataIn_w, DataOut;
    logic        DataInValid, DataInValid_w, DataInReady;
    logic        DataOutValid, DataOutReady, DataOutReady_w;

    always #5 clk = ~clk;

    uart_mmio_ctrl dut (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .wr_en(wr_en), .stall(stall),
        .addr(addr), .wdata(wdata), .rdata(rdata), .hit(hit),
        .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
    );

    // Narrow-counter instance shares all stimulus; only its CYCLE reads differ.
    uart_mmio_ctrl #(.CNT_WIDTH(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .wr_en(wr_en), .stall(stall),
        .addr(addr), .wdata(wdata), .rdata(rdata_w), .hit(hit_w),
        .DataIn(DataIn_w), .DataInValid(DataInValid_w), .DataInReady(DataInReady),
        .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady_w)
    );

    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        logic [31:0] rd_w;
        bit          dinv;
        logic [7:0]  din;
        bit          dor;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       me;
    logic [7:0] tx_m[$];
    logic [7:0] rx_m[$];
    bit         tx_ovf_m, rx_ovf_m;
    logic [31:0] cnt_m;
    int         nchecks = 0;
    int         nerrors = 0;

    function automatic bit sel(input logic [31:0] a);
        return (a[31:28] == 4'b1000) && (a[27:5] == 23'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input bit narrow);
        if (!sel(a)) return 32'd0;
        case (a[4:2])
            3'd0: return {30'd0, tx_ovf_m, (tx_m.size() < DEPTH)};
            3'd1: return {30'd0, rx_ovf_m, (rx_m.size() > 0)};
            3'd2: return (rx_m.size() > 0) ? {24'd0, rx_m[0]} : 32'd0;
            3'd4: return narrow ? {28'd0, cnt_m[3:0]} : cnt_m;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nchecks++;
        if (act !== req) begin
            nerrors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("DataInValid", {31'd0, DataInValid}, {31'd0, me.dinv});
            chk("DataOutReady", {31'd0, DataOutReady}, {31'd0, me.dor});
            if (me.dinv) chk("DataIn", {24'd0, DataIn}, {24'd0, me.din});
            if (me.chk_rd) begin
                chk("rdata", rdata, me.rd);
                chk("rdata_cnt4", rdata_w, me.rd_w);
            end
        end
    end

    task automatic model_update();
        bit acc, txpop;
        int txn, rxn;
        logic [2:0] off;
        acc   = sel(addr) && !stall;
        off   = addr[4:2];
        txn   = tx_m.size();
        rxn   = rx_m.size();
        txpop = (txn > 0) && DataInReady;
        if (acc && wr_en && off == 3'd5) begin
            if (wdata[0]) tx_ovf_m = 1'b0;
            if (wdata[1]) rx_ovf_m = 1'b0;
        end
        if (txpop) void'(tx_m.pop_front());
        if (acc && wr_en && off == 3'd3) begin
            if (txn < DEPTH || txpop) tx_m.push_back(wdata[7:0]);
            else tx_ovf_m = 1'b1;
        end
        if (acc && rd_en && off == 3'd2 && rxn > 0) void'(rx_m.pop_front());
        if (DataOutValid) begin
            if (rxn < DEPTH) rx_m.push_back(DataOut);
            else rx_ovf_m = 1'b1;
        end
        cnt_m = (acc && wr_en && off == 3'd4) ? 32'd1 : cnt_m + 32'd1;
    endtask

    task automatic push_exp();
        exp_t e;
        e.chk_rd = rd_en;
        e.rd     = exp_read(addr, 1'b0);
        e.rd_w   = exp_read(addr, 1'b1);
        e.dinv   = (tx_m.size() > 0);
        e.din    = (tx_m.size() > 0) ? tx_m[0] : 8'h00;
        e.dor    = (rx_m.size() < DEPTH);
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        push_exp();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic op_a(input bit r, input bit w, input bit s, input logic [31:0] a, input logic [31:0] wd);
        rd_en = r; wr_en = w; stall = s; addr = a; wdata = wd;
        cycle();
    endtask

    task automatic op(input bit r, input bit w, input bit s, input logic [2:0] off, input logic [31:0] wd);
        op_a(r, w, s, {4'b1000, 23'd0, off, 2'b00}, wd);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rd_en = 1'b1; wr_en = 1'b0; stall = 1'b0; addr = 32'h0000_0010; wdata = 32'd0;
        tx_m.delete(); rx_m.delete();
        tx_ovf_m = 1'b0; rx_ovf_m = 1'b0; cnt_m = 32'd0;
        push_exp();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        DataInReady = 1'b0; DataOutValid = 1'b0; DataOut = 8'h00;
        do_reset();

        op(1, 0, 0, 3'd4, 0);
        op(1, 0, 0, 3'd0, 0);
        op(1, 0, 0, 3'd1, 0);
        op(1, 0, 0, 3'd2, 0);
        op(1, 0, 0, 3'd6, 0);
        op_a(1, 0, 0, 32'h8000_0020, 0);
        op_a(1, 0, 0, 32'h9000_0000, 0);

        for (int i = 0; i < 8; i++) op(0, 1, 0, 3'd3, 32'h41 + i);
        op(1, 0, 0, 3'd0, 0);
        op(0, 1, 0, 3'd3, 32'h49);
        op(1, 0, 0, 3'd0, 0);
        op(0, 1, 0, 3'd5, 32'h1);
        op(1, 0, 0, 3'd0, 0);
        DataInReady = 1'b1;
        op(0, 1, 0, 3'd3, 32'h4A);
        DataInReady = 1'b0;
        op(1, 0, 0, 3'd0, 0);
        DataInReady = 1'b1;
        repeat (10) op(0, 0, 0, 3'd0, 0);
        DataInReady = 1'b0;

        DataOutValid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            DataOut = 8'h60 + 8'(i);
            op(0, 0, 0, 3'd0, 0);
        end
        op(0, 1, 0, 3'd5, 32'h2);
        DataOutValid = 1'b0;
        op(1, 0, 0, 3'd1, 0);
        for (int i = 0; i < 9; i++) op(1, 0, 0, 3'd2, 0);
        op(1, 0, 0, 3'd1, 0);
        op(0, 1, 0, 3'd5, 32'h3);
        op(1, 0, 0, 3'd1, 0);

        DataOutValid = 1'b1; DataOut = 8'h77;
        op(0, 0, 0, 3'd0, 0);
        DataOutValid = 1'b0;
        op(1, 0, 1, 3'd2, 0);
        op(0, 1, 1, 3'd3, 32'h55);
        op(1, 0, 0, 3'd1, 0);
        op(1, 0, 0, 3'd0, 0);
        op(1, 0, 0, 3'd2, 0);
        op(1, 0, 0, 3'd1, 0);

        for (int i = 0; i < 3; i++) op(0, 1, 0, 3'd3, 32'h30 + i);
        DataOutValid = 1'b1; DataOut = 8'h99;
        do_reset();
        DataOutValid = 1'b0;
        op(1, 0, 0, 3'd4, 0);
        op(1, 0, 0, 3'd1, 0);
        op(1, 0, 0, 3'd0, 0);

        repeat (3) op(0, 0, 0, 3'd0, 0);
        op(0, 1, 0, 3'd4, 0);
        repeat (20) op(1, 0, 0, 3'd4, 0);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            a = {4'b1000, 23'd0, 3'($urandom_range(0, 7)), 2'b00};
            if ($urandom_range(0, 9) == 0) a[6] = 1'b1;
            DataInReady  = ($urandom_range(0, 2) == 0);
            DataOutValid = ($urandom_range(0, 1) == 1);
            DataOut      = 8'($urandom);
            op_a(($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) == 0), a, $urandom);
        end

        DataInReady = 1'b0; DataOutValid = 1'b0;
        rd_en = 1'b0; wr_en = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
